block_addr_gen: RTL and testbench
=================================

BLOCK_ADDR_GEN -- requirements
Module: block_addr_gen

Interface
REQ-001 SHALL have parameter BLK_COLS, default 8, image width in 8x8 blocks (>=1).
REQ-002 SHALL have parameter BLK_ROWS, default 8, image height in 8x8 blocks (>=1).
REQ-003 SHALL have parameter ADDR_W, default 12, pixel address width; must satisfy 2^ADDR_W >= BLK_COLS*BLK_ROWS*64.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle request to scan a full frame.
REQ-007 SHALL have port ready  input  1  downstream accepts current address this cycle.
REQ-008 SHALL have port addr  output  ADDR_W  raster-order pixel address of current block pixel.
REQ-009 SHALL have port addr_valid  output  1  addr is valid.
REQ-010 SHALL have port blk_first  output  1  current addr is pixel (0,0) of a block.
REQ-011 SHALL have port blk_last  output  1  current addr is pixel (7,7) of a block.
REQ-012 SHALL have port busy  output  1  scan in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse after final transfer of a frame.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 IDLE: start=1 -> RUN next cycle with all counters zero; start=0 -> stay IDLE.
REQ-016 RUN: transfer occurs on a cycle with addr_valid=1 and ready=1; counters advance only on transfer.
REQ-017 RUN: transfer of the final pixel of the final block -> DONE next cycle.
REQ-018 DONE: lasts exactly one cycle, done=1, then IDLE unconditionally.
REQ-019 SHALL keep 3-bit pixel column pc, 3-bit pixel row pr, block column bc, block row br.
REQ-020 Advance order per transfer: pc increments; pc wrap 7->0 increments pr; pr wrap 7->0 increments bc; bc wrap BLK_COLS-1->0 increments br.
REQ-021 addr SHALL equal (br*8+pr)*(BLK_COLS*8) + bc*8 + pc, computed at full precision then truncated to ADDR_W.
REQ-022 addr, blk_first, blk_last SHALL be registered, combinationally independent of ready and start.
REQ-023 addr_valid=1 and busy=1 exactly in RUN; addr_valid=0 in IDLE and DONE.
REQ-024 blk_first = addr_valid & pc==0 & pr==0; blk_last = addr_valid & pc==7 & pr==7.
REQ-025 With ready=0 in RUN, addr, blk_first, blk_last SHALL hold unchanged (no drop, no repeat).
REQ-026 start SHALL be ignored in RUN and DONE; no restart, no counter disturbance.
REQ-027 start asserted in the same cycle done=1 SHALL be ignored; a new scan requires start in IDLE.
REQ-028 Total transfers per frame SHALL be exactly BLK_COLS*BLK_ROWS*64.
REQ-029 BLK_COLS=1 or BLK_ROWS=1 SHALL work (bc/br wrap immediately).

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE, all counters 0, addr=0, addr_valid=0, blk_first=0, blk_last=0, busy=0, done=0.
REQ-031 rst SHALL take priority over start, ready, and any FSM transition, including mid-frame and in DONE.
REQ-032 After rst deasserts, block SHALL stay IDLE until a fresh start; no partial frame resumes.

Verification (defaults 8x8 blocks, ADDR_W=12)
REQ-033 rst, then start pulse, ready=1 constant -> addr sequence 0,1..7,64,65..,455 (blk_last at 455), then 8 with blk_first=1.
REQ-034 Full frame, ready=1 -> 4096 transfers, last addr 4095 with blk_last=1, done=1 for exactly one cycle next, then IDLE.
REQ-035 Random ready pattern -> identical 4096-address sequence as REQ-033/034; addr held stable on every ready=0 cycle.
REQ-036 start pulsed during RUN at transfer 100 and during DONE -> sequence unaffected, no second frame starts.
REQ-037 rst asserted at transfer 300 -> next cycle addr_valid=0, busy=0, addr=0; new start restarts at addr 0.
REQ-038 BLK_COLS=3, BLK_ROWS=1, ADDR_W=8 -> block 1 first addr 8, block 2 last addr 7*24+23=191, 192 transfers.

Source files
------------

// File: rtl/block_addr_gen.sv
// block_addr_gen: walks a frame of 8x8 pixel blocks in block-raster order and
// emits the raster-order pixel address of every pixel. Each block is scanned
// row by row. Output handshake is valid/ready, and a one-cycle done pulse
// follows the last transfer of the frame.
module block_addr_gen #(
  parameter int BLK_COLS = 8,
  parameter int BLK_ROWS = 8,
  parameter int ADDR_W   = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ready,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  output logic              blk_first,
  output logic              blk_last,
  output logic              busy,
  output logic              done
);

  localparam int BC_W = (BLK_COLS > 1) ? $clog2(BLK_COLS) : 1;
  localparam int BR_W = (BLK_ROWS > 1) ? $clog2(BLK_ROWS) : 1;

  localparam logic [BC_W-1:0] BC_MAX = BC_W'(BLK_COLS - 1);
  localparam logic [BR_W-1:0] BR_MAX = BR_W'(BLK_ROWS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state, state_nx;
  logic [2:0]        pc, pc_nx;
  logic [2:0]        pr, pr_nx;
  logic [BC_W-1:0]   bc, bc_nx;
  logic [BR_W-1:0]   br, br_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic              first_nx;
  logic              last_nx;

  // Next-state and counter advance; counters move only on an accepted transfer.
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    pr_nx    = pr;
    bc_nx    = bc;
    br_nx    = br;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = RUN;
          pc_nx    = '0;
          pr_nx    = '0;
          bc_nx    = '0;
          br_nx    = '0;
        end
      end
      RUN: begin
        if (ready) begin
          pc_nx = pc + 3'd1;
          if (pc == 3'd7) begin
            pr_nx = pr + 3'd1;
            if (pr == 3'd7) begin
              if (bc == BC_MAX) begin
                bc_nx = '0;
                if (br == BR_MAX) begin
                  br_nx    = '0;
                  state_nx = DONE;
                end else begin
                  br_nx = br + BR_W'(1);
                end
              end else begin
                bc_nx = bc + BC_W'(1);
              end
            end
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Address of the next pixel, so addr and the block flags can be registered.
  // Only + and * are involved, so evaluating modulo 2^ADDR_W gives the same
  // result as full-precision evaluation followed by truncation.
  always_comb begin
    addr_nx = (ADDR_W'(br_nx) * ADDR_W'(8) + ADDR_W'(pr_nx)) * ADDR_W'(BLK_COLS * 8)
            + ADDR_W'(bc_nx) * ADDR_W'(8) + ADDR_W'(pc_nx);
    first_nx = (state_nx == RUN) && (pc_nx == 3'd0) && (pr_nx == 3'd0);
    last_nx  = (state_nx == RUN) && (pc_nx == 3'd7) && (pr_nx == 3'd7);
    if (state_nx != RUN) begin
      addr_nx = '0;
    end
  end

  // State, counters and registered outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= '0;
      pr        <= '0;
      bc        <= '0;
      br        <= '0;
      addr      <= '0;
      blk_first <= 1'b0;
      blk_last  <= 1'b0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      pr        <= pr_nx;
      bc        <= bc_nx;
      br        <= br_nx;
      addr      <= addr_nx;
      blk_first <= first_nx;
      blk_last  <= last_nx;
    end
  end

  assign addr_valid = (state == RUN);
  assign busy       = (state == RUN);
  assign done       = (state == DONE);

endmodule

// File: tb/tb_block_addr_gen.sv
// Directed bench for block_addr_gen: default 8x8-block frame plus a 3x1-block
// instance. Expected addresses come from a pixel-index formula in the bench.
module tb_block_addr_gen;

  logic        clk = 1'b0;
  logic        rst, start, ready;
  logic [11:0] addr;
  logic        addr_valid, blk_first, blk_last, busy, done;

  logic        s_rst, s_start, s_ready;
  logic [7:0]  s_addr;
  logic        s_valid, s_first, s_last, s_busy, s_done;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  block_addr_gen #(.BLK_COLS(8), .BLK_ROWS(8), .ADDR_W(12)) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready), .addr(addr),
    .addr_valid(addr_valid), .blk_first(blk_first), .blk_last(blk_last),
    .busy(busy), .done(done)
  );

  block_addr_gen #(.BLK_COLS(3), .BLK_ROWS(1), .ADDR_W(8)) dut_small (
    .clk(clk), .rst(s_rst), .start(s_start), .ready(s_ready), .addr(s_addr),
    .addr_valid(s_valid), .blk_first(s_first), .blk_last(s_last),
    .busy(s_busy), .done(s_done)
  );

  // Pixel index n of the frame scan -> raster pixel address.
  function automatic int unsigned exp_addr(int unsigned n, int unsigned cols);
    int unsigned b, w;
    b = n / 64;
    w = n % 64;
    return ((b / cols) * 8 + w / 8) * (cols * 8) + (b % cols) * 8 + (w % 8);
  endfunction

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; ready = 1'b1;
    s_rst = 1'b1; s_start = 1'b0; s_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({addr_valid, busy, done, blk_first, blk_last} !== 5'b0)
      $display("FAIL reset_flags: got v=%b b=%b d=%b f=%b l=%b expected all 0",
               addr_valid, busy, done, blk_first, blk_last);
    else passed++;
    total++;
    if (addr !== 12'd0) $display("FAIL reset_addr: got %0d expected 0", addr);
    else passed++;
    rst = 1'b0; start = 1'b0; s_rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || addr_valid !== 1'b0)
      $display("FAIL idle_after_reset: got busy=%b v=%b expected 0 0", busy, addr_valid);
    else passed++;
  endtask

  task automatic test_full_frame;
    logic [11:0] e;
    logic ef, el;
    ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int unsigned n = 0; n < 4096; n++) begin
      e = 12'(exp_addr(n, 8));
      ef = (n % 64 == 0);
      el = (n % 64 == 63);
      total++;
      if (addr_valid !== 1'b1 || addr !== e || blk_first !== ef || blk_last !== el)
        $display("FAIL frame_seq n=%0d: got addr=%0d v=%b f=%b l=%b expected addr=%0d v=1 f=%b l=%b",
                 n, addr, addr_valid, blk_first, blk_last, e, ef, el);
      else passed++;
      @(negedge clk);
    end
    total++;
    if (done !== 1'b1 || addr_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL frame_done: got d=%b v=%b b=%b expected 1 0 0", done, addr_valid, busy);
    else passed++;
    @(negedge clk);
    total++;
    if (done !== 1'b0 || addr_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL frame_idle: got d=%b v=%b b=%b expected 0 0 0", done, addr_valid, busy);
    else passed++;
  endtask

  task automatic test_random_ready;
    int unsigned n, cyc;
    logic [11:0] e, prev;
    logic ef, el, r, prev_r;
    n = 0; cyc = 0; prev = '0; prev_r = 1'b1;
    ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (n < 4096 && cyc < 20000) begin
      e = 12'(exp_addr(n, 8));
      ef = (n % 64 == 0);
      el = (n % 64 == 63);
      total++;
      if (addr_valid !== 1'b1 || addr !== e || blk_first !== ef || blk_last !== el)
        $display("FAIL rand_seq n=%0d: got addr=%0d v=%b f=%b l=%b expected addr=%0d v=1 f=%b l=%b",
                 n, addr, addr_valid, blk_first, blk_last, e, ef, el);
      else passed++;
      if (!prev_r) begin
        total++;
        if (addr !== prev) $display("FAIL rand_hold n=%0d: got %0d expected %0d", n, addr, prev);
        else passed++;
      end
      prev = addr;
      r = 1'($urandom_range(0, 1));
      ready = r;
      prev_r = r;
      if (r) n++;
      @(negedge clk);
      cyc++;
    end
    total++;
    if (n != 4096) $display("FAIL rand_budget: got %0d transfers expected 4096", n);
    else passed++;
    total++;
    if (done !== 1'b1 || addr_valid !== 1'b0)
      $display("FAIL rand_done: got d=%b v=%b expected 1 0", done, addr_valid);
    else passed++;
    ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_start_ignored;
    logic [11:0] e;
    ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int unsigned n = 0; n < 4096; n++) begin
      e = 12'(exp_addr(n, 8));
      total++;
      if (addr_valid !== 1'b1 || addr !== e)
        $display("FAIL start_run_seq n=%0d: got addr=%0d v=%b expected addr=%0d v=1",
                 n, addr, addr_valid, e);
      else passed++;
      start = (n == 100);
      @(negedge clk);
    end
    start = 1'b0;
    total++;
    if (done !== 1'b1) $display("FAIL start_done: got %b expected 1", done);
    else passed++;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || addr_valid !== 1'b0)
      $display("FAIL start_in_done: got d=%b b=%b v=%b expected 0 0 0", done, busy, addr_valid);
    else passed++;
    repeat (4) @(negedge clk);
    total++;
    if (busy !== 1'b0) $display("FAIL no_restart: got busy=%b expected 0", busy);
    else passed++;
  endtask

  task automatic test_reset_midframe;
    logic [11:0] e;
    ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int unsigned n = 0; n <= 300; n++) begin
      e = 12'(exp_addr(n, 8));
      total++;
      if (addr_valid !== 1'b1 || addr !== e)
        $display("FAIL pre_rst_seq n=%0d: got addr=%0d v=%b expected addr=%0d v=1",
                 n, addr, addr_valid, e);
      else passed++;
      if (n < 300) @(negedge clk);
    end
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    total++;
    if (addr_valid !== 1'b0 || busy !== 1'b0 || addr !== 12'd0 || done !== 1'b0)
      $display("FAIL mid_rst: got v=%b b=%b addr=%0d d=%b expected 0 0 0 0",
               addr_valid, busy, addr, done);
    else passed++;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0) $display("FAIL no_resume: got busy=%b expected 0", busy);
    else passed++;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int unsigned n = 0; n < 20; n++) begin
      e = 12'(exp_addr(n, 8));
      total++;
      if (addr_valid !== 1'b1 || addr !== e || blk_first !== (n == 0))
        $display("FAIL restart_seq n=%0d: got addr=%0d v=%b f=%b expected addr=%0d v=1",
                 n, addr, addr_valid, blk_first, e);
      else passed++;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_small_frame;
    logic [7:0] e;
    s_ready = 1'b1;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    for (int unsigned n = 0; n < 192; n++) begin
      e = 8'(exp_addr(n, 3));
      total++;
      if (s_valid !== 1'b1 || s_addr !== e || s_first !== (n % 64 == 0) || s_last !== (n % 64 == 63))
        $display("FAIL small_seq n=%0d: got addr=%0d v=%b f=%b l=%b expected addr=%0d",
                 n, s_addr, s_valid, s_first, s_last, e);
      else passed++;
      if (n == 64) begin
        total++;
        if (s_addr !== 8'd8 || s_first !== 1'b1)
          $display("FAIL small_blk1_first: got addr=%0d f=%b expected 8 1", s_addr, s_first);
        else passed++;
      end
      if (n == 191) begin
        total++;
        if (s_addr !== 8'd191 || s_last !== 1'b1)
          $display("FAIL small_blk2_last: got addr=%0d l=%b expected 191 1", s_addr, s_last);
        else passed++;
      end
      @(negedge clk);
    end
    total++;
    if (s_done !== 1'b1 || s_valid !== 1'b0)
      $display("FAIL small_done: got d=%b v=%b expected 1 0", s_done, s_valid);
    else passed++;
    @(negedge clk);
    total++;
    if (s_done !== 1'b0 || s_busy !== 1'b0)
      $display("FAIL small_idle: got d=%b b=%b expected 0 0", s_done, s_busy);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_random_ready();
    test_start_ignored();
    test_reset_midframe();
    test_small_frame();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
